rr_req_arbiter_8: RTL and testbench
===================================

Name: rr_req_arbiter_8

Overview:
- Captures 8 independent request lines and issues a single one-hot grant word using round-robin priority.
- Sits directly upstream of the 8:3 encoder. o_gnt drives the encoder's i_i0..i_i7 (bit k to i_ik). o_gnt_valid drives its i_en.
- Guarantees the encoder only ever sees a one-hot or all-zero input.
- A downstream consumer acknowledges each grant with a valid/ready handshake.

Parameters:
- NUM_REQ, 8: request count. Fixed at 8 to match the encoder; other values are unsupported.
- IDX_W, 3: width of the internal priority pointer (log2 NUM_REQ).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst_n  input  1  synchronous reset, active-low
- i_en  input  1  capture/issue enable
- i_req  input  8  request lines, level-sampled each cycle
- i_gnt_ready  input  1  consumer accepts the current grant
- o_gnt  output  8  one-hot grant; all zeros when o_gnt_valid=0
- o_gnt_valid  output  1  o_gnt holds a live grant
- o_pending  output  8  registered pending-request vector
- o_busy  output  1  (|o_pending) || o_gnt_valid

Behaviour:
- Reset: on any rising edge with i_rst_n=0:
  - pending=0, ptr=0, o_gnt=0, o_gnt_valid=0, state=IDLE.
  - This overrides all other activity. A grant in flight is dropped, not completed.
- Capture:
  - Each edge with i_en=1: pending |= i_req.
  - With i_en=0: nothing is captured and pending is retained.
- Grant clear: on an accept edge (o_gnt_valid && i_gnt_ready), the granted bit is cleared from pending. If i_req has that same bit high in that cycle, the bit stays set and counts as a new request.
- Pick function: first set bit of the candidate vector, scanning from index ptr upward with wrap 7->0. A candidate of zero gives no grant.
- State IDLE (o_gnt_valid=0):
  - If i_en=1 and registered pending != 0: load o_gnt = pick(pending, ptr), set o_gnt_valid=1, go to GRANT.
  - Requests arriving this cycle are not considered until the next edge.
  - Latency: i_req high before edge k gives o_gnt_valid=1 after edge k+1.
- State GRANT, i_gnt_ready=0: o_gnt and o_gnt_valid hold stable. New requests still accumulate in pending.
- State GRANT, accept edge:
  - ptr = (granted index + 1) mod 8.
  - Let rem = pending & ~o_gnt, using registered pending only.
  - If i_en=1 and rem != 0: load o_gnt = pick(rem, new ptr) and stay in GRANT. This gives back-to-back grants with no bubble.
  - Otherwise: o_gnt=0, o_gnt_valid=0, go to IDLE.
- i_en deasserted during GRANT: the current grant stays valid until accepted. No further grant is issued while i_en=0.
- Invariants:
  - o_gnt has at most one bit set.
  - o_gnt=0 whenever o_gnt_valid=0.
  - A granted bit is always set in pending.
- Fairness: with all 8 requests continuously high, grants cycle 0,1,...,7,0. No requester waits more than 7 accepts.
- ptr changes only on accept edges.

Decomposition:
- Package rr_arb_pkg holds:
  - NUM_REQ and IDX_W
  - state encoding {ST_IDLE, ST_GRANT}
  - a function for one-hot to index, used for the ptr update
- One combinational sub-module, rr_pick_8: inputs are an 8-bit candidate and a 3-bit ptr; outputs are an 8-bit one-hot and a found flag. It is implemented as rotate, fixed-priority, rotate-back.
- The sub-module is instantiated twice: once for the IDLE pick and once for the back-to-back pick.

Test Plan:
- Reset: drive i_rst_n=0 for 2 edges while i_req=8'hFF and i_en=1 -> o_gnt=0, o_gnt_valid=0, o_pending=0, o_busy=0. Release -> o_pending=8'hFF one edge later.
- Single request: i_en=1, pulse i_req=8'h08 for one cycle, i_gnt_ready=0 -> two edges later o_gnt=8'h08 and valid=1, held 5 cycles. Raise ready -> next edge o_gnt=0, valid=0, o_pending=0, and the encoder downstream read 3'b011.
- Round-robin: i_req=8'hFF continuously, i_gnt_ready=1 -> grant sequence 01,02,04,...,80,01 on consecutive edges with no bubbles.
- Pointer fairness: after accepting a grant of 8'h04, set pending={bit1, bit6} -> next grant is 8'h40, then 8'h02.
- Same-bit re-request: o_gnt=8'h10, accept with i_req=8'h10 in the same cycle -> o_pending[4] stays 1. With no other requests, 8'h10 is granted again.
- Enable/reset mid-grant: with o_gnt=8'h01 and pending=8'h03, set i_en=0 and then accept -> valid drops and 8'h02 stays pending with no grant. Re-enable -> 8'h02 is granted. Assert reset while valid=1 -> all outputs 0 on that edge.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared sizes, state encoding and one-hot decode for the round-robin arbiter
package rr_arb_pkg;
    localparam int NUM_REQ = 8;
    localparam int IDX_W = 3;
    typedef enum logic {ST_IDLE, ST_GRANT} state_t;
    function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) idx = oh[i] ? IDX_W'(i) : idx;
        return idx;
    endfunction
endpackage

// File: rtl/rr_pick_8.sv
// rr_pick_8: first set candidate bit at or above ptr, wrapping 7->0, as one-hot
module rr_pick_8
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] cand,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               found
);
    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] fp;
    always_comb begin
        rot = '0;
        gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) rot[i] = cand[IDX_W'(i) + ptr];
        fp = rot & (~rot + NUM_REQ'(1));
        for (int i = 0; i < NUM_REQ; i++) gnt[IDX_W'(i) + ptr] = fp[i];
        found = |cand;
    end
endmodule

// File: rtl/rr_req_arbiter_8.sv
// rr_req_arbiter_8: accumulates 8 request lines and issues round-robin one-hot grants under valid/ready
module rr_req_arbiter_8
    import rr_arb_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_gnt_ready,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_gnt_valid,
    output logic [NUM_REQ-1:0] o_pending,
    output logic               o_busy
);
    state_t             state;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] rem;
    logic [NUM_REQ-1:0] idle_gnt;
    logic [NUM_REQ-1:0] b2b_gnt;
    logic               idle_found;
    logic               b2b_found;
    logic               accept;
    always_comb begin
        accept = gnt_valid && i_gnt_ready;
        next_ptr = onehot_idx(gnt) + IDX_W'(1);
        rem = pending & ~gnt;
    end
    rr_pick_8 u_pick_idle (.cand(pending), .ptr(ptr),      .gnt(idle_gnt), .found(idle_found));
    rr_pick_8 u_pick_b2b  (.cand(rem),     .ptr(next_ptr), .gnt(b2b_gnt),  .found(b2b_found));
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pending   <= '0;
            ptr       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            state     <= ST_IDLE;
        end else begin
            // an accepted bit re-requested in the same cycle survives as a new request
            pending <= (pending & ~(accept ? gnt : '0)) | (i_en ? i_req : '0);
            if (state == ST_IDLE) begin
                if (i_en && idle_found) begin
                    gnt       <= idle_gnt;
                    gnt_valid <= 1'b1;
                    state     <= ST_GRANT;
                end
            end else if (accept) begin
                ptr <= next_ptr;
                if (i_en && b2b_found) begin
                    gnt <= b2b_gnt;
                end else begin
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            end
        end
    end
    assign o_gnt       = gnt;
    assign o_gnt_valid = gnt_valid;
    assign o_pending   = pending;
    assign o_busy      = (|pending) || gnt_valid;
endmodule

// File: tb/tb_rr_req_arbiter_8.sv
// tb_rr_req_arbiter_8: scoreboard bench comparing the arbiter against a cycle-level reference model
module tb_rr_req_arbiter_8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [7:0] req = '0;
    logic       ready = 1'b0;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [7:0] pending;
    logic       busy;

    typedef struct {
        bit [7:0] gnt;
        bit       valid;
        bit [7:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit [7:0] m_pend = '0;
    int   m_ptr = 0;
    int   m_gnt = -1;

    rr_req_arbiter_8 dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_req(req), .i_gnt_ready(ready),
        .o_gnt(gnt), .o_gnt_valid(gnt_valid), .o_pending(pending), .o_busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int pick(bit [7:0] c, int p);
        for (int k = 0; k < 8; k++) if (c[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    task automatic check(string name, int act, int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    endtask

    // apply one cycle of inputs and predict the registered outputs after the edge
    task automatic step(bit r_n, bit e, bit [7:0] rq, bit rdy);
        bit [7:0] old;
        bit [7:0] rem;
        bit       acc;
        exp_t     x;
        @(negedge clk);
        rst_n = r_n; en = e; req = rq; ready = rdy;
        if (!r_n) begin
            m_pend = '0; m_ptr = 0; m_gnt = -1;
        end else begin
            old = m_pend;
            acc = (m_gnt >= 0) && rdy;
            if (acc) m_pend[m_gnt] = 1'b0;
            if (e) m_pend |= rq;
            if (m_gnt < 0) begin
                if (e && old != 0) m_gnt = pick(old, m_ptr);
            end else if (acc) begin
                m_ptr = (m_gnt + 1) % 8;
                rem = old;
                rem[m_gnt] = 1'b0;
                m_gnt = (e && rem != 0) ? pick(rem, m_ptr) : -1;
            end
        end
        x.valid = (m_gnt >= 0);
        x.gnt = x.valid ? (8'd1 << m_gnt) : 8'd0;
        x.pend = m_pend;
        exp_q.push_back(x);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("gnt", int'(gnt), int'(e.gnt));
            check("gnt_valid", int'(gnt_valid), int'(e.valid));
            check("pending", int'(pending), int'(e.pend));
            check("busy", int'(busy), int'(e.pend != 0 || e.valid));
            check("onehot", int'($countones(gnt) <= 1), 1);
        end
    end

    initial begin
        // reset dominates live requests, then a released edge captures all
        step(0, 1, 8'hFF, 0);
        step(0, 1, 8'hFF, 0);
        step(1, 1, 8'hFF, 0);
        // single request held then accepted
        step(0, 1, 8'h00, 0);
        step(1, 1, 8'h08, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 8'h00, 0);
        step(1, 1, 8'h00, 1);
        step(1, 1, 8'h00, 0);
        // round-robin with every requester continuously active
        step(0, 1, 8'h00, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 8'hFF, 1);
        // pointer fairness after granting bit 2
        step(0, 1, 8'h00, 0);
        step(1, 1, 8'h04, 0);
        step(1, 1, 8'h00, 0);
        step(1, 1, 8'h00, 1);
        step(1, 1, 8'h42, 0);
        step(1, 1, 8'h00, 0);
        step(1, 1, 8'h00, 1);
        step(1, 1, 8'h00, 1);
        // same-bit re-request on the accept edge
        step(0, 1, 8'h00, 0);
        step(1, 1, 8'h10, 0);
        step(1, 1, 8'h00, 0);
        step(1, 1, 8'h10, 1);
        step(1, 1, 8'h00, 0);
        step(1, 1, 8'h00, 1);
        // enable dropped mid-grant, then re-enabled, then reset mid-grant
        step(0, 1, 8'h00, 0);
        step(1, 1, 8'h03, 0);
        step(1, 1, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 0);
        step(1, 1, 8'h00, 0);
        step(1, 1, 8'h00, 0);
        step(0, 1, 8'hFF, 1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit [7:0] rq;
            rq = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step($urandom_range(0, 199) != 0, $urandom_range(0, 7) != 0, rq, $urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
